branch_resolver: RTL

EX-stage branch/jump resolution unit for the miniRV pipeline. It drives the sign-select input of the EX comparator and consumes its {less, equal} flags. It decides taken/not-taken for conditional branches, JAL and JALR, then owns the redirect to IF through a valid/ready handshake, flushing younger stages until the redirect is accepted. It also keeps wrap-around performance counters for branches resolved and branches taken.

---
 rtl/branch_resolver_pkg.sv | 30 +++
 rtl/branch_resolver_perf_cnt.sv | 18 +
 rtl/branch_resolver.sv | 117 +++++++++++
 3 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the EX-stage branch resolver: funct3 encodings,
// FSM state encoding and the conditional-branch taken rule.
package branch_resolver_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_REDIR = 1'b1
    } state_e;

    // 010/011 are not real branches but are still counted as resolved, never taken.
    function automatic logic br_cond(input logic [2:0] f3, input logic lt, input logic eq);
        logic r;
        case (f3)
            F3_BEQ:           r = eq;
            F3_BNE:           r = ~eq;
            F3_BLT, F3_BLTU:  r = lt;
            F3_BGE, F3_BGEU:  r = ~lt;
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_resolver_perf_cnt.sv
// Wrapping performance counter with enable and async active-low clear.
module br_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            cnt_o <= '0;
        else if (en_i)
            cnt_o <= cnt_o + CNT_W'(1);
    end

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch/jump resolution: taken decision, target capture, redirect
// handshake to IF with flush of younger stages, and branch performance counters.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             ex_valid_i,
    input  logic             ex_is_br_i,
    input  logic             ex_is_jal_i,
    input  logic             ex_is_jalr_i,
    input  logic [2:0]       ex_funct3_i,
    input  logic [XLEN-1:0]  ex_pc_i,
    input  logic [XLEN-1:0]  ex_imm_i,
    input  logic [XLEN-1:0]  ex_rs1_i,
    output logic             cmp_sign_o,
    input  logic [1:0]       cmp_i,
    output logic [XLEN-1:0]  link_o,
    output logic             redir_valid_o,
    input  logic             redir_ready_i,
    output logic [XLEN-1:0]  redir_pc_o,
    output logic             misalign_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] br_total_o,
    output logic [CNT_W-1:0] br_taken_o
);

    state_e          r_state;
    state_e          w_state_nxt;
    logic            w_is_jal;
    logic            w_is_br;
    logic            w_br_taken;
    logic            w_taken;
    logic            w_resolve;
    logic            w_capture;
    logic            w_flush;
    logic            w_cnt_en;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] r_redir_pc;
    logic            r_misalign;

    assign cmp_sign_o = ~ex_funct3_i[1];
    assign link_o     = ex_pc_i + XLEN'(4);

    // Priority jalr > jal > br when decode raises more than one flag.
    assign w_is_jal   = ex_is_jal_i & ~ex_is_jalr_i;
    assign w_is_br    = ex_is_br_i & ~ex_is_jal_i & ~ex_is_jalr_i;
    assign w_br_taken = br_cond(ex_funct3_i, cmp_i[1], cmp_i[0]);
    assign w_taken    = ex_is_jalr_i | w_is_jal | (w_is_br & w_br_taken);
    assign w_resolve  = ex_valid_i & w_taken;
    assign w_target   = ex_is_jalr_i ? ((ex_rs1_i + ex_imm_i) & ~XLEN'(1))
                                     : (ex_pc_i + ex_imm_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_flush     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_resolve) begin
                    w_flush     = 1'b1;
                    w_capture   = 1'b1;
                    w_state_nxt = ST_REDIR;
                end
            end
            ST_REDIR: begin
                w_flush = 1'b1;
                if (redir_ready_i)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_redir_pc <= '0;
            r_misalign <= 1'b0;
        end else if (w_capture) begin
            r_redir_pc <= w_target;
            r_misalign <= w_target[1];
        end
    end

    assign redir_valid_o = (r_state == ST_REDIR);
    assign redir_pc_o    = r_redir_pc;
    assign misalign_o    = r_misalign;
    // The IDLE-state flush is combinational from EX, so hold it low during reset too.
    assign flush_o       = w_flush & rst_n_i;

    assign w_cnt_en = (r_state == ST_IDLE) & ex_valid_i & w_is_br;

    br_perf_cnt #(.CNT_W(CNT_W)) u_cnt_total (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (w_cnt_en),
        .cnt_o   (br_total_o)
    );

    br_perf_cnt #(.CNT_W(CNT_W)) u_cnt_taken (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (w_cnt_en & w_br_taken),
        .cnt_o   (br_taken_o)
    );

endmodule
